// File: rtl/pipe_pkg.sv
// Shared definitions for the 16-bit pipeline: default widths and the MEM-stage access state.
package pipe_pkg;

    localparam int DEF_DATA_WIDTH     = 16;
    localparam int DEF_ADDR_WIDTH     = 8;
    localparam int DEF_IMM8_WIDTH     = 8;
    localparam int DEF_REG_WIDTH      = 4;
    localparam int DEF_TIMEOUT_CYCLES = 15;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } mem_state_t;

endpackage

// File: rtl/dmem_access_fsm.sv
// Data-memory req/ack sequencer with read-data capture for accesses that finish under a MEM/WB hold.
// Optional watchdog abort is enabled by defining DMEM_TIMEOUT_EN.
module dmem_access_fsm
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_op,
    input  logic                  ack,
    input  logic                  hold,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  req,
    output logic                  stall,
    output logic                  state_done,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  err
);

    mem_state_t            state;
    mem_state_t            state_next;
    logic                  complete;
    logic                  timeout;
    logic [DATA_WIDTH-1:0] cap_data;

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_WIDTH-1:0] wait_cnt;
    logic                 err_q;

    assign timeout = (state == WAIT) && (wait_cnt == CNT_WIDTH'(TIMEOUT_CYCLES));
    assign err     = err_q;

    // Counter restarts on every entry to WAIT; the error flag is sticky until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state != WAIT) begin
                wait_cnt <= '0;
            end else if (!timeout) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cap_data <= '0;
        end else begin
            state <= state_next;
            if (complete) begin
                cap_data <= timeout ? '0 : rdata;
            end
        end
    end

    // An aborted access completes like an ack but with zero data and no request.
    always_comb begin
        state_next = state;
        req        = 1'b0;
        stall      = 1'b0;
        complete   = 1'b0;
        unique case (state)
            IDLE: begin
                req = mem_op;
                if (mem_op) begin
                    if (ack) begin
                        complete = 1'b1;
                        if (hold) begin
                            state_next = DONE;
                        end
                    end else begin
                        stall      = 1'b1;
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (timeout) begin
                    complete   = 1'b1;
                    state_next = hold ? DONE : IDLE;
                end else begin
                    req   = 1'b1;
                    stall = !ack;
                    if (ack) begin
                        complete   = 1'b1;
                        state_next = hold ? DONE : IDLE;
                    end
                end
            end
            DONE: begin
                if (!hold) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign state_done = (state == DONE);
    assign read_data  = (state == DONE)         ? cap_data :
                        (complete && !timeout)  ? rdata    : '0;

endmodule

// File: rtl/mem_stage.sv
// MEM stage: branch resolution, MEM->EX forwarding value, data-memory access and the MEM/WB register.
// Define DMEM_TIMEOUT_EN to enable the data-memory watchdog and dmem_err_o.
module mem_stage
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int IMM8_WIDTH     = DEF_IMM8_WIDTH,
    parameter int REG_WIDTH      = DEF_REG_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] PCM_i,
    input  logic [DATA_WIDTH-1:0] WriteDataM_i,
    input  logic [IMM8_WIDTH-1:0] imm8M_i,
    input  logic [REG_WIDTH-1:0]  WriteRegM_i,
    input  logic [DATA_WIDTH-1:0] alu_outM_i,
    input  logic                  RegWriteM_i,
    input  logic                  BranchM_i,
    input  logic                  MemReadM_i,
    input  logic                  MemWriteM_i,
    input  logic                  MemToRegM_i,
    input  logic                  MovM_i,
    input  logic                  flush_MEM_WB_i,
    input  logic                  stall_MEM_WB_i,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [ADDR_WIDTH-1:0] dmem_addr_o,
    output logic [DATA_WIDTH-1:0] dmem_wdata_o,
    input  logic                  dmem_ack_i,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
    output logic                  stall_mem_o,
    output logic                  PCSrcM_o,
    output logic [ADDR_WIDTH-1:0] BranchTargetM_o,
    output logic [DATA_WIDTH-1:0] WBResultM_o,
    output logic                  RegWriteW_o,
    output logic                  MemToRegW_o,
    output logic [REG_WIDTH-1:0]  WriteRegW_o,
    output logic [DATA_WIDTH-1:0] alu_outW_o,
    output logic [DATA_WIDTH-1:0] ReadDataW_o,
    output logic                  dmem_err_o
);

    logic                  mem_op;
    logic                  access_done;
    logic [DATA_WIDTH-1:0] read_data;

    assign mem_op          = MemReadM_i | MemWriteM_i;
    assign PCSrcM_o        = BranchM_i & (alu_outM_i == '0);
    assign BranchTargetM_o = PCM_i + ADDR_WIDTH'(imm8M_i);
    assign WBResultM_o     = MovM_i ? {{(DATA_WIDTH-IMM8_WIDTH){1'b0}}, imm8M_i} : alu_outM_i;
    assign dmem_we_o       = MemWriteM_i;
    assign dmem_addr_o     = alu_outM_i[ADDR_WIDTH-1:0];
    assign dmem_wdata_o    = WriteDataM_i;

    dmem_access_fsm #(
        .DATA_WIDTH     (DATA_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_access (
        .clk        (clk),
        .rst        (rst),
        .mem_op     (mem_op),
        .ack        (dmem_ack_i),
        .hold       (stall_MEM_WB_i),
        .rdata      (dmem_rdata_i),
        .req        (dmem_req_o),
        .stall      (stall_mem_o),
        .state_done (access_done),
        .read_data  (read_data),
        .err        (dmem_err_o)
    );

    // Hazard-unit hold outranks our own stall so a held instruction is never replaced by a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteW_o <= 1'b0;
            MemToRegW_o <= 1'b0;
            WriteRegW_o <= '0;
            alu_outW_o  <= '0;
            ReadDataW_o <= '0;
        end else if (flush_MEM_WB_i) begin
            RegWriteW_o <= 1'b0;
            MemToRegW_o <= 1'b0;
            WriteRegW_o <= '0;
            alu_outW_o  <= '0;
            ReadDataW_o <= '0;
        end else if (stall_MEM_WB_i) begin
            RegWriteW_o <= RegWriteW_o;
            MemToRegW_o <= MemToRegW_o;
            WriteRegW_o <= WriteRegW_o;
            alu_outW_o  <= alu_outW_o;
            ReadDataW_o <= ReadDataW_o;
        end else if (stall_mem_o) begin
            RegWriteW_o <= 1'b0;
            MemToRegW_o <= 1'b0;
            WriteRegW_o <= '0;
            alu_outW_o  <= '0;
            ReadDataW_o <= '0;
        end else begin
            RegWriteW_o <= RegWriteM_i;
            MemToRegW_o <= MemToRegM_i;
            WriteRegW_o <= WriteRegM_i;
            alu_outW_o  <= WBResultM_o;
            ReadDataW_o <= access_done ? read_data : (dmem_ack_i ? read_data : '0);
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: loads, stores with wait states, branch, MOV, held ack and reset.
// The watchdog scenario is exercised when DMEM_TIMEOUT_EN is defined.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  PCM_i = '0;
    logic [15:0] WriteDataM_i = '0;
    logic [7:0]  imm8M_i = '0;
    logic [3:0]  WriteRegM_i = '0;
    logic [15:0] alu_outM_i = '0;
    logic        RegWriteM_i = 1'b0, BranchM_i = 1'b0, MemReadM_i = 1'b0;
    logic        MemWriteM_i = 1'b0, MemToRegM_i = 1'b0, MovM_i = 1'b0;
    logic        flush_MEM_WB_i = 1'b0, stall_MEM_WB_i = 1'b0;
    logic        dmem_req_o, dmem_we_o;
    logic [7:0]  dmem_addr_o;
    logic [15:0] dmem_wdata_o;
    logic        dmem_ack_i = 1'b0;
    logic [15:0] dmem_rdata_i = '0;
    logic        stall_mem_o, PCSrcM_o;
    logic [7:0]  BranchTargetM_o;
    logic [15:0] WBResultM_o;
    logic        RegWriteW_o, MemToRegW_o;
    logic [3:0]  WriteRegW_o;
    logic [15:0] alu_outW_o, ReadDataW_o;
    logic        dmem_err_o;

    int checks = 0;
    int failures = 0;
    int write_count = 0;

    mem_stage dut (
        .clk(clk), .rst(rst), .PCM_i(PCM_i), .WriteDataM_i(WriteDataM_i), .imm8M_i(imm8M_i),
        .WriteRegM_i(WriteRegM_i), .alu_outM_i(alu_outM_i), .RegWriteM_i(RegWriteM_i),
        .BranchM_i(BranchM_i), .MemReadM_i(MemReadM_i), .MemWriteM_i(MemWriteM_i),
        .MemToRegM_i(MemToRegM_i), .MovM_i(MovM_i), .flush_MEM_WB_i(flush_MEM_WB_i),
        .stall_MEM_WB_i(stall_MEM_WB_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i),
        .dmem_rdata_i(dmem_rdata_i), .stall_mem_o(stall_mem_o), .PCSrcM_o(PCSrcM_o),
        .BranchTargetM_o(BranchTargetM_o), .WBResultM_o(WBResultM_o), .RegWriteW_o(RegWriteW_o),
        .MemToRegW_o(MemToRegW_o), .WriteRegW_o(WriteRegW_o), .alu_outW_o(alu_outW_o),
        .ReadDataW_o(ReadDataW_o), .dmem_err_o(dmem_err_o)
    );

    always #5 clk = ~clk;

    // Count completed write handshakes seen on the bus.
    always @(posedge clk) begin
        if (rst && dmem_req_o && dmem_we_o && dmem_ack_i) write_count++;
    end

    task automatic clear_inputs;
        PCM_i = '0; WriteDataM_i = '0; imm8M_i = '0; WriteRegM_i = '0; alu_outM_i = '0;
        RegWriteM_i = 0; BranchM_i = 0; MemReadM_i = 0; MemWriteM_i = 0; MemToRegM_i = 0; MovM_i = 0;
        flush_MEM_WB_i = 0; stall_MEM_WB_i = 0; dmem_ack_i = 0; dmem_rdata_i = '0;
    endtask

    task automatic test_reset;
        #1;
        rst = 1'b0;
        #1;
        checks++; if (dmem_req_o !== 1'b0) begin failures++; $display("FAIL reset_req got=%h exp=0", dmem_req_o); end
        checks++; if (stall_mem_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%h exp=0", stall_mem_o); end
        checks++; if (RegWriteW_o !== 1'b0) begin failures++; $display("FAIL reset_regwrite got=%h exp=0", RegWriteW_o); end
        checks++; if (ReadDataW_o !== 16'h0000) begin failures++; $display("FAIL reset_readdata got=%h exp=0000", ReadDataW_o); end
        checks++; if (alu_outW_o !== 16'h0000) begin failures++; $display("FAIL reset_aluout got=%h exp=0000", alu_outW_o); end
        checks++; if (dmem_err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%h exp=0", dmem_err_o); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_zero_wait_load;
        @(posedge clk); #1;
        MemReadM_i = 1; MemToRegM_i = 1; RegWriteM_i = 1; WriteRegM_i = 4'd3;
        alu_outM_i = 16'h0012; dmem_ack_i = 1; dmem_rdata_i = 16'hBEEF;
        #1;
        checks++; if (stall_mem_o !== 1'b0) begin failures++; $display("FAIL load_stall got=%h exp=0", stall_mem_o); end
        checks++; if (dmem_req_o !== 1'b1) begin failures++; $display("FAIL load_req got=%h exp=1", dmem_req_o); end
        checks++; if (dmem_addr_o !== 8'h12) begin failures++; $display("FAIL load_addr got=%h exp=12", dmem_addr_o); end
        @(posedge clk); #1;
        checks++; if (ReadDataW_o !== 16'hBEEF) begin failures++; $display("FAIL load_readdata got=%h exp=beef", ReadDataW_o); end
        checks++; if (MemToRegW_o !== 1'b1) begin failures++; $display("FAIL load_memtoreg got=%h exp=1", MemToRegW_o); end
        checks++; if (WriteRegW_o !== 4'd3) begin failures++; $display("FAIL load_writereg got=%h exp=3", WriteRegW_o); end
        clear_inputs();
    endtask

    task automatic test_store_wait;
        @(posedge clk); #1;
        MemWriteM_i = 1; WriteDataM_i = 16'h1234; alu_outM_i = 16'h0040; dmem_ack_i = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({dmem_req_o, dmem_we_o, stall_mem_o} !== 3'b111) begin failures++; $display("FAIL store_wait%0d req/we/stall got=%b exp=111", i, {dmem_req_o, dmem_we_o, stall_mem_o}); end
            checks++; if (dmem_wdata_o !== 16'h1234 || dmem_addr_o !== 8'h40) begin failures++; $display("FAIL store_bus%0d got=%h@%h exp=1234@40", i, dmem_wdata_o, dmem_addr_o); end
            @(posedge clk); #1;
            checks++; if (alu_outW_o !== 16'h0000) begin failures++; $display("FAIL store_bubble%0d got=%h exp=0000", i, alu_outW_o); end
        end
        dmem_ack_i = 1;
        #1;
        checks++; if (stall_mem_o !== 1'b0) begin failures++; $display("FAIL store_ack_stall got=%h exp=0", stall_mem_o); end
        @(posedge clk); #1;
        checks++; if (alu_outW_o !== 16'h0040) begin failures++; $display("FAIL store_wb got=%h exp=0040", alu_outW_o); end
        checks++; if (write_count !== 1) begin failures++; $display("FAIL store_writes got=%0d exp=1", write_count); end
        clear_inputs();
        #1;
        checks++; if (dmem_req_o !== 1'b0) begin failures++; $display("FAIL store_req_after got=%h exp=0", dmem_req_o); end
    endtask

    task automatic test_branch;
        @(posedge clk); #1;
        BranchM_i = 1; alu_outM_i = 16'h0000; PCM_i = 8'h10; imm8M_i = 8'hFE;
        #1;
        checks++; if (PCSrcM_o !== 1'b1) begin failures++; $display("FAIL branch_taken got=%h exp=1", PCSrcM_o); end
        checks++; if (BranchTargetM_o !== 8'h0E) begin failures++; $display("FAIL branch_target got=%h exp=0e", BranchTargetM_o); end
        alu_outM_i = 16'h0001;
        #1;
        checks++; if (PCSrcM_o !== 1'b0) begin failures++; $display("FAIL branch_not_taken got=%h exp=0", PCSrcM_o); end
        BranchM_i = 0; alu_outM_i = 16'h0000;
        #1;
        checks++; if (PCSrcM_o !== 1'b0) begin failures++; $display("FAIL branch_disabled got=%h exp=0", PCSrcM_o); end
        clear_inputs();
    endtask

    task automatic test_mov;
        @(posedge clk); #1;
        MovM_i = 1; imm8M_i = 8'hA5; RegWriteM_i = 1; WriteRegM_i = 4'd7; alu_outM_i = 16'h3333;
        #1;
        checks++; if (WBResultM_o !== 16'h00A5) begin failures++; $display("FAIL mov_wbresult got=%h exp=00a5", WBResultM_o); end
        @(posedge clk); #1;
        checks++; if (alu_outW_o !== 16'h00A5) begin failures++; $display("FAIL mov_aluoutw got=%h exp=00a5", alu_outW_o); end
        checks++; if (RegWriteW_o !== 1'b1 || WriteRegW_o !== 4'd7) begin failures++; $display("FAIL mov_dest got=%h/%h exp=1/7", RegWriteW_o, WriteRegW_o); end
        MovM_i = 0;
        #1;
        checks++; if (WBResultM_o !== 16'h3333) begin failures++; $display("FAIL nomov_wbresult got=%h exp=3333", WBResultM_o); end
        clear_inputs();
    endtask

    task automatic test_ack_during_stall;
        @(posedge clk); #1;
        MemReadM_i = 1; MemToRegM_i = 1; RegWriteM_i = 1; WriteRegM_i = 4'd5; alu_outM_i = 16'h0020;
        @(posedge clk); #1;
        dmem_ack_i = 1; dmem_rdata_i = 16'hCAFE; stall_MEM_WB_i = 1;
        #1;
        checks++; if (stall_mem_o !== 1'b0) begin failures++; $display("FAIL held_ack_stall got=%h exp=0", stall_mem_o); end
        @(posedge clk); #1;
        dmem_ack_i = 0; dmem_rdata_i = 16'hDEAD;
        #1;
        checks++; if (dmem_req_o !== 1'b0) begin failures++; $display("FAIL held_done_req1 got=%h exp=0", dmem_req_o); end
        checks++; if (ReadDataW_o !== 16'h0000) begin failures++; $display("FAIL held_hold_readdata got=%h exp=0000", ReadDataW_o); end
        @(posedge clk); #1;
        stall_MEM_WB_i = 0;
        #1;
        checks++; if (dmem_req_o !== 1'b0 || stall_mem_o !== 1'b0) begin failures++; $display("FAIL held_done_req2 got=%h/%h exp=0/0", dmem_req_o, stall_mem_o); end
        @(posedge clk); #1;
        checks++; if (ReadDataW_o !== 16'hCAFE) begin failures++; $display("FAIL held_readdata got=%h exp=cafe", ReadDataW_o); end
        checks++; if ({RegWriteW_o, MemToRegW_o, WriteRegW_o} !== 6'b11_0101) begin failures++; $display("FAIL held_ctrl got=%b exp=110101", {RegWriteW_o, MemToRegW_o, WriteRegW_o}); end
        clear_inputs();
    endtask

    task automatic test_reset_mid_access;
        @(posedge clk); #1;
        MovM_i = 1; imm8M_i = 8'h5A; RegWriteM_i = 1; WriteRegM_i = 4'd9;
        @(posedge clk); #1;
        clear_inputs();
        MemReadM_i = 1; alu_outM_i = 16'h0030; stall_MEM_WB_i = 1;
        @(posedge clk); #1;
        checks++; if (dmem_req_o !== 1'b1 || stall_mem_o !== 1'b1) begin failures++; $display("FAIL midreset_wait got=%h/%h exp=1/1", dmem_req_o, stall_mem_o); end
        checks++; if (WriteRegW_o !== 4'd9 || alu_outW_o !== 16'h005A) begin failures++; $display("FAIL midreset_hold got=%h/%h exp=9/005a", WriteRegW_o, alu_outW_o); end
        rst = 1'b0;
        clear_inputs();
        #1;
        checks++; if (dmem_req_o !== 1'b0 || stall_mem_o !== 1'b0) begin failures++; $display("FAIL midreset_req got=%h/%h exp=0/0", dmem_req_o, stall_mem_o); end
        checks++; if ({RegWriteW_o, WriteRegW_o, alu_outW_o} !== 21'd0) begin failures++; $display("FAIL midreset_wb got=%h exp=0", {RegWriteW_o, WriteRegW_o, alu_outW_o}); end
        #2;
        rst = 1'b1;
        @(posedge clk); #1;
        MemReadM_i = 1; alu_outM_i = 16'h0031; dmem_ack_i = 1; dmem_rdata_i = 16'h7777;
        #1;
        checks++; if (stall_mem_o !== 1'b0 || dmem_req_o !== 1'b1) begin failures++; $display("FAIL postreset_idle got=%h/%h exp=0/1", stall_mem_o, dmem_req_o); end
        @(posedge clk); #1;
        clear_inputs();
    endtask

`ifdef DMEM_TIMEOUT_EN
    task automatic test_timeout;
        int n;
        n = 0;
        @(posedge clk); #1;
        MemReadM_i = 1; MemToRegM_i = 1; alu_outM_i = 16'h0050; dmem_ack_i = 0;
        #1;
        while (stall_mem_o === 1'b1 && n < 40) begin
            n++;
            @(posedge clk); #2;
        end
        checks++; if (n !== 16) begin failures++; $display("FAIL timeout_cycles got=%0d exp=16", n); end
        checks++; if (dmem_req_o !== 1'b0) begin failures++; $display("FAIL timeout_req got=%h exp=0", dmem_req_o); end
        @(posedge clk); #1;
        checks++; if (dmem_err_o !== 1'b1) begin failures++; $display("FAIL timeout_err got=%h exp=1", dmem_err_o); end
        checks++; if (ReadDataW_o !== 16'h0000) begin failures++; $display("FAIL timeout_readdata got=%h exp=0000", ReadDataW_o); end
        clear_inputs();
        @(posedge clk); #1;
        checks++; if (dmem_err_o !== 1'b1) begin failures++; $display("FAIL timeout_sticky got=%h exp=1", dmem_err_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_zero_wait_load();
        test_store_wait();
        test_branch();
        test_mov();
        test_ack_during_stall();
        test_reset_mid_access();
`ifdef DMEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
